rsb_serial_sub: RTL and testbench

//   Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/rsb_serial_sub.sv | 171 +++++++++++++++++
 tb/tb_rsb_serial_sub.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rsb_serial_sub.sv
// -----------------------------------------------------------------------------
// rsb_serial_sub
//   Bit-serial ripple-borrow subtractor. Computes diff = a - b - bin (modulo
//   2^W) one bit per clock, LSB first, with a start/busy/done handshake. The
//   result registers hold the last completed result until the next completion.
//
//   Optional feature macro: RSB_OVF_EN
//     defined   -> ovf port present (signed overflow of the last result)
//     undefined -> ovf port and its logic absent
//
// Parameters
//   W      operand width in bits (W >= 2)
//   CNT_W  bit-counter width, derived internally as $clog2(W)+1
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE or DONE
//   a      minuend, captured when start is accepted
//   b      subtrahend, captured when start is accepted
//   bin    borrow-in, captured when start is accepted
//   busy   high while bits are being processed (exactly W cycles)
//   done   one-cycle pulse; diff/bout valid from this cycle on
//   diff   a - b - bin, modulo 2^W
//   bout   borrow-out (1 when a < b + bin, unsigned)
//   ovf    signed overflow (RSB_OVF_EN only)
// -----------------------------------------------------------------------------
module rsb_serial_sub #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef RSB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [W-1:0]       a_sh_reg;
    logic [W-1:0]       b_sh_reg;
    logic               br_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // Holds the W-1 difference bits produced so far; the final bit is
    // appended combinationally on the last step, so no extra cycle is needed.
    logic [W-2:0]       diff_sh_reg;
    logic [W-1:0]       diff_reg;
    logic               bout_reg;
`ifdef RSB_OVF_EN
    logic               ovf_reg;
`endif

    logic               accept;
    logic               last_bit;
    logic               a_i;
    logic               b_i;
    logic               d_i;
    logic               br_next;
    logic [W-1:0]       diff_cat;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // One-bit full subtractor on the current LSBs of the operand shifters
    // ---------------------------------------------------------------------
    always_comb begin
        last_bit = (cnt_reg == CNT_W'(W - 1));
        a_i      = a_sh_reg[0];
        b_i      = b_sh_reg[0];
        d_i      = a_i ^ b_i ^ br_reg;
        br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br_reg);
        diff_cat = {d_i, diff_sh_reg};
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            br_reg      <= 1'b0;
            cnt_reg     <= '0;
            diff_sh_reg <= '0;
            diff_reg    <= '0;
            bout_reg    <= 1'b0;
`ifdef RSB_OVF_EN
            ovf_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_sh_reg    <= a;
                b_sh_reg    <= b;
                br_reg      <= bin;
                cnt_reg     <= '0;
                diff_sh_reg <= '0;
            end else if (state_reg == S_BUSY) begin
                a_sh_reg    <= a_sh_reg >> 1;
                b_sh_reg    <= b_sh_reg >> 1;
                br_reg      <= br_next;
                cnt_reg     <= cnt_reg + CNT_W'(1);
                diff_sh_reg <= diff_cat[W-1:1];
                if (last_bit) begin
                    diff_reg <= diff_cat;
                    bout_reg <= br_next;
`ifdef RSB_OVF_EN
                    // On the last step a_i/b_i are the captured operand MSBs.
                    ovf_reg  <= (a_i ^ b_i) & (d_i ^ a_i);
`endif
                end
            end
        end
    end

    assign busy = (state_reg == S_BUSY);
    assign done = (state_reg == S_DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef RSB_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_rsb_serial_sub.sv
module tb_rsb_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef RSB_OVF_EN
    logic         ovf;
`endif

    rsb_serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef RSB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever done is presented
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", int'(busy & done), 0);
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_cycle"}, cyc, e.cyc);
                check({e.name, "_diff"}, int'(diff), int'(e.diff));
                check({e.name, "_bout"}, int'(bout), int'(e.bout));
`ifdef RSB_OVF_EN
                check({e.name, "_ovf"}, int'(ovf), int'(e.ovf));
`endif
                $display("op %s: diff=%0h bout=%0b at cycle %0d", e.name, diff, bout, cyc);
            end
        end
    end

    // Issue one start with a result expectation (next edge accepts).
    task automatic issue(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input logic [W-1:0] ed, input logic eb,
                         input logic eo);
        exp_t e;
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        e.diff = ed;
        e.bout = eb;
        e.ovf  = eo;
        e.cyc  = cyc + 1 + W;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || done) && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 50) check("drain_timeout", 1, 0);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] ed, input logic eb,
                          input logic eo);
        @(negedge clk);
        issue(nm, av, bv, bi, ed, eb, eo);
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
`ifdef RSB_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        //      name        a      b      bin   diff   bout  ovf
        run_op("9m3",     4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b1);
        run_op("3m9",     4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b1);
        run_op("0m0b",    4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0);
        run_op("FmFb",    4'hF,  4'hF,  1'b1, 4'hF, 1'b1, 1'b0);
        run_op("Fm0",     4'hF,  4'h0,  1'b0, 4'hF, 1'b0, 1'b0);
        run_op("0mF",     4'h0,  4'hF,  1'b0, 4'h1, 1'b1, 1'b0);
        run_op("8m1",     4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1);
        run_op("7m1",     4'd7,  4'd1,  1'b0, 4'h6, 1'b0, 1'b0);
        run_op("5m5b",    4'd5,  4'd5,  1'b1, 4'hF, 1'b1, 1'b0);
        run_op("Cm4b",    4'hC,  4'h4,  1'b1, 4'h7, 1'b0, 1'b1);

        // start re-pulsed on the 2nd BUSY cycle must be ignored
        @(negedge clk);
        issue("ign", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1);
        @(negedge clk);            // 1st BUSY cycle
        start = 1'b0;
        @(negedge clk);            // 2nd BUSY cycle
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // reset asserted during the 3rd BUSY cycle discards the operation
        @(negedge clk);
        a     = 4'd9;
        b     = 4'd3;
        start = 1'b1;
        @(negedge clk);            // 1st BUSY cycle
        start = 1'b0;
        @(negedge clk);            // 2nd
        @(negedge clk);            // 3rd
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_bout", int'(bout), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // start held high: two back-to-back operations, done every W+1 cycles
        k = cyc + 1;
        issue("hold1", 4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 1'b0);
        @(negedge clk);
        a = 4'd2;
        b = 4'd5;
        begin
            exp_t e;
            e.diff = 4'hD;
            e.bout = 1'b1;
            e.ovf  = 1'b0;
            e.cyc  = k + 2 * W + 1;
            e.name = "hold2";
            exp_q.push_back(e);
        end
        while (cyc < k + W + 1) @(negedge clk);
        start = 1'b0;
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
